// File: rtl/wei_instr_issue_pkg.sv
// ============================================================================
// Module      : wei_pkg
// Description : Shared constants, instruction field layout and FSM encoding
//               for the weight-instruction initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wei_pkg;
    localparam int NUM_PEB     = 16;
    localparam int PEB_IDX_W   = 4;
    localparam int PE_NUM      = 27;
    localparam int INSTR_WIDTH = 8;
    localparam int CNT_WIDTH   = 12;
    localparam int LEN_MSB     = 7;
    localparam int LEN_LSB     = 5;
    localparam int PE_MSB      = 4;
    localparam int PE_LSB      = 0;
    localparam int LEN_W       = LEN_MSB - LEN_LSB + 1;
    localparam int PE_W        = PE_MSB - PE_LSB + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [INSTR_WIDTH-1:0] pack_instr(
        input logic [LEN_W-1:0] len,
        input logic [PE_W-1:0]  pe
    );
        logic [INSTR_WIDTH-1:0] v;
        v                   = '0;
        v[LEN_MSB:LEN_LSB]  = len;
        v[PE_MSB:PE_LSB]    = pe;
        return v;
    endfunction
endpackage

`default_nettype wire

// File: rtl/wei_instr_issue_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; search starts at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N = 16,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] grant,
    output logic [W-1:0] winner,
    output logic         any
);

    // Scan offsets from farthest to nearest so the last hit is closest to ptr.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        grant  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                any    = 1'b1;
                winner = W'((int'(ptr) + i) % N);
            end
        end
        if (en && any) begin
            grant[winner] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wei_instr_issue.sv
// ============================================================================
// Module      : wei_instr_issue
// Description : Round-robin weight-instruction initiator from PEB array to GB.
//               Optional WEI_ISSUE_STATS_EN adds stall_cnt / issue_cnt outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wei_instr_issue
    import wei_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        CCUWEI_start,
    input  logic                        CCUWEI_flush,
    input  logic [CNT_WIDTH-1:0]        Instr_num,
    input  logic [NUM_PEB-1:0]          PEB_req_val,
    input  logic [NUM_PEB*PE_W-1:0]     PEB_req_pe,
    input  logic [NUM_PEB*LEN_W-1:0]    PEB_req_len,
    output logic [NUM_PEB-1:0]          PEB_req_rdy,
    output logic                        WEIGB_instr_val,
    input  logic                        GBWEI_instr_rdy,
    output logic [PEB_IDX_W-1:0]        Which_PEB,
    output logic [INSTR_WIDTH-1:0]      WEIGB_instr_data,
    output logic                        issue_done,
    output logic                        drop_err
`ifdef WEI_ISSUE_STATS_EN
   ,output logic [15:0]                 stall_cnt,
    output logic [15:0]                 issue_cnt
`endif
);

    localparam logic [PE_W-1:0]      c_PE_LIMIT = PE_W'(PE_NUM);
    localparam logic [PEB_IDX_W-1:0] c_LAST_PEB = PEB_IDX_W'(NUM_PEB - 1);

    state_t                   r_state;
    logic                     r_hold_v;
    logic [PEB_IDX_W-1:0]     r_which;
    logic [INSTR_WIDTH-1:0]   r_data;
    logic [CNT_WIDTH-1:0]     r_count;
    logic [PEB_IDX_W-1:0]     r_ptr;
    logic                     r_issue_done;
    logic                     r_drop_err;

    logic                     w_fire;
    logic                     w_budget_last;
    logic                     w_can_load;
    logic                     w_any;
    logic                     w_taken;
    logic                     w_bad;
    logic [NUM_PEB-1:0]       w_grant;
    logic [PEB_IDX_W-1:0]     w_winner;
    logic [PEB_IDX_W-1:0]     w_next_ptr;
    logic [LEN_W-1:0]         w_len;
    logic [PE_W-1:0]          w_pe;

    assign w_fire        = r_hold_v & GBWEI_instr_rdy;
    assign w_budget_last = w_fire & (Instr_num != '0) & (r_count == Instr_num - 1'b1);
    // The last budgeted fire must not pull in a request that would never be issued.
    assign w_can_load    = (r_state == RUN) & ~CCUWEI_flush & (~r_hold_v | w_fire) & ~w_budget_last;

    rr_arbiter #(
        .N (NUM_PEB),
        .W (PEB_IDX_W)
    ) u_arb (
        .req    (PEB_req_val),
        .ptr    (r_ptr),
        .en     (w_can_load),
        .grant  (w_grant),
        .winner (w_winner),
        .any    (w_any)
    );

    assign w_taken    = w_can_load & w_any;
    assign w_len      = PEB_req_len[w_winner*LEN_W +: LEN_W];
    assign w_pe       = PEB_req_pe[w_winner*PE_W +: PE_W];
    assign w_bad      = (w_len == '0) | (w_pe >= c_PE_LIMIT);
    assign w_next_ptr = (w_winner == c_LAST_PEB) ? '0 : w_winner + 1'b1;

    assign PEB_req_rdy      = w_grant;
    assign WEIGB_instr_val  = r_hold_v;
    assign Which_PEB        = r_which;
    assign WEIGB_instr_data = r_data;
    assign issue_done       = r_issue_done;
    assign drop_err         = r_drop_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_hold_v     <= 1'b0;
            r_which      <= '0;
            r_data       <= '0;
            r_count      <= '0;
            r_ptr        <= '0;
            r_issue_done <= 1'b0;
            r_drop_err   <= 1'b0;
        end else begin
            r_issue_done <= w_budget_last;

            if (CCUWEI_flush) begin
                r_state <= IDLE;
            end else if (CCUWEI_start) begin
                r_state <= RUN;
            end else if (r_state == RUN && w_budget_last) begin
                r_state <= DONE;
            end

            // A concurrent fire still reaches GB, but flush forgets it.
            if (CCUWEI_flush) begin
                r_hold_v <= 1'b0;
            end else if (w_taken && !w_bad) begin
                r_hold_v <= 1'b1;
                r_which  <= w_winner;
                r_data   <= pack_instr(w_len, w_pe);
            end else if (w_fire) begin
                r_hold_v <= 1'b0;
            end

            if (CCUWEI_flush || CCUWEI_start) begin
                r_count <= '0;
            end else if (w_fire) begin
                r_count <= r_count + 1'b1;
            end

            if (CCUWEI_start) begin
                r_ptr <= '0;
            end else if (w_taken) begin
                r_ptr <= w_next_ptr;
            end

            if (CCUWEI_start) begin
                r_drop_err <= 1'b0;
            end
            if (w_taken && w_bad) begin
                r_drop_err <= 1'b1;
            end
        end
    end

`ifdef WEI_ISSUE_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_issue_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_issue_cnt <= '0;
        end else if (CCUWEI_start) begin
            r_stall_cnt <= '0;
            r_issue_cnt <= '0;
        end else begin
            if (r_hold_v && !GBWEI_instr_rdy && r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_fire && r_issue_cnt != 16'hFFFF) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign issue_cnt = r_issue_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wei_instr_issue.sv
// ============================================================================
// Module      : tb_wei_instr_issue
// Description : Scoreboard bench for wei_instr_issue with per-PEB request queues.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wei_instr_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        CCUWEI_start;
    logic        CCUWEI_flush;
    logic [11:0] Instr_num;
    logic [15:0] PEB_req_val;
    logic [79:0] PEB_req_pe;
    logic [47:0] PEB_req_len;
    logic [15:0] PEB_req_rdy;
    logic        WEIGB_instr_val;
    logic        GBWEI_instr_rdy;
    logic [3:0]  Which_PEB;
    logic [7:0]  WEIGB_instr_data;
    logic        issue_done;
    logic        drop_err;
`ifdef WEI_ISSUE_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] issue_cnt;
`endif

    wei_instr_issue dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .CCUWEI_start     (CCUWEI_start),
        .CCUWEI_flush     (CCUWEI_flush),
        .Instr_num        (Instr_num),
        .PEB_req_val      (PEB_req_val),
        .PEB_req_pe       (PEB_req_pe),
        .PEB_req_len      (PEB_req_len),
        .PEB_req_rdy      (PEB_req_rdy),
        .WEIGB_instr_val  (WEIGB_instr_val),
        .GBWEI_instr_rdy  (GBWEI_instr_rdy),
        .Which_PEB        (Which_PEB),
        .WEIGB_instr_data (WEIGB_instr_data),
        .issue_done       (issue_done),
        .drop_err         (drop_err)
`ifdef WEI_ISSUE_STATS_EN
       ,.stall_cnt        (stall_cnt),
        .issue_cnt        (issue_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Per-PEB pending requests, each entry {len[2:0], pe[4:0]}.
    logic [7:0] pq [16][64];
    int         ph [16];
    int         pt [16];

    logic [11:0] exp_q [$];
    logic [11:0] e;
    int done_cnt = 0;
    int cur_run  = 0;
    int max_run  = 0;
    int ngrant   = 0;
    bit prev_vgrant = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 16; i++) begin
            if (ph[i] != pt[i]) begin
                PEB_req_val[i]       = 1'b1;
                PEB_req_pe[5*i +: 5] = pq[i][ph[i]][4:0];
                PEB_req_len[3*i +: 3] = pq[i][ph[i]][7:5];
            end else begin
                PEB_req_val[i]       = 1'b0;
                PEB_req_pe[5*i +: 5] = 5'd0;
                PEB_req_len[3*i +: 3] = 3'd0;
            end
        end
    endtask

    task automatic add_req(input int peb, input int pe, input int len);
        logic [7:0] v;
        v = {3'(len), 5'(pe)};
        pq[peb][pt[peb]] = v;
        pt[peb]++;
        drive();
    endtask

    task automatic expect_issue(input int peb, input int data);
        exp_q.push_back({4'(peb), 8'(data)});
    endtask

    // One cycle: observe grants at negedge, then present the next request heads.
    task automatic tick();
        @(negedge clk);
        if (prev_vgrant) chk("grant_to_val", int'(WEIGB_instr_val), 1);
        prev_vgrant = 1'b0;
        if (PEB_req_rdy != 16'd0) chk("grant_onehot", $countones(PEB_req_rdy), 1);
        for (int i = 0; i < 16; i++) begin
            if (PEB_req_rdy[i]) begin
                ngrant++;
                if (ph[i] == pt[i]) begin
                    chk("grant_without_req", i, -1);
                end else begin
                    if (pq[i][ph[i]][7:5] != 3'd0 && pq[i][ph[i]][4:0] < 5'd27)
                        prev_vgrant = 1'b1;
                    ph[i]++;
                end
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    function automatic int pending();
        int s;
        s = 0;
        for (int i = 0; i < 16; i++) s += pt[i] - ph[i];
        return s;
    endfunction

    task automatic run_until_drained(input string nm, input int max);
        for (int n = 0; n < max; n++) begin
            if (exp_q.size() == 0 && pending() == 0) return;
            tick();
        end
        chk({nm, "_timeout"}, exp_q.size() + pending(), 0);
    endtask

    task automatic pulse_start();
        CCUWEI_start = 1'b1;
        tick();
        CCUWEI_start = 1'b0;
    endtask

    // Monitor: every fire pops one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (WEIGB_instr_val) begin
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
            end else begin
                cur_run = 0;
            end
            if (issue_done) done_cnt++;
            if (WEIGB_instr_val && GBWEI_instr_rdy) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_issue: got peb %0d data 0x%02h, required none",
                             Which_PEB, WEIGB_instr_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({Which_PEB, WEIGB_instr_data} !== e) begin
                        fails++;
                        $display("FAIL issue: got peb %0d data 0x%02h, required peb %0d data 0x%02h",
                                 Which_PEB, WEIGB_instr_data, e[11:8], e[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        int ng0;
        for (int i = 0; i < 16; i++) begin
            ph[i] = 0;
            pt[i] = 0;
        end
        rst_n           = 1'b0;
        CCUWEI_start    = 1'b0;
        CCUWEI_flush    = 1'b0;
        Instr_num       = 12'd0;
        GBWEI_instr_rdy = 1'b1;
        PEB_req_val     = '0;
        PEB_req_pe      = '0;
        PEB_req_len     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        chk("rst_val",        int'(WEIGB_instr_val), 0);
        chk("rst_which",      int'(Which_PEB), 0);
        chk("rst_data",       int'(WEIGB_instr_data), 0);
        chk("rst_req_rdy",    int'(PEB_req_rdy), 0);
        chk("rst_issue_done", int'(issue_done), 0);
        chk("rst_drop_err",   int'(drop_err), 0);
        @(posedge clk);
        #1;

        // Budget of 3 from a single persistent requester.
        Instr_num = 12'd3;
        for (int k = 0; k < 3; k++) begin
            add_req(2, 5, 4);
            expect_issue(2, 8'h85);
        end
        pulse_start();
        run_until_drained("budget3", 40);
        repeat (3) tick();
        chk("issue_done_pulses", done_cnt, 1);
        add_req(2, 5, 4);
        repeat (5) tick();
        chk("done_no_grant", pt[2] - ph[2], 1);
        pt[2] = ph[2];
        drive();

        // Round-robin order with back-to-back issue.
        Instr_num = 12'd0;
        add_req(0, 1, 1);
        add_req(0, 3, 2);
        add_req(1, 26, 7);
        add_req(15, 0, 3);
        expect_issue(0, 8'h21);
        expect_issue(1, 8'hFA);
        expect_issue(15, 8'h60);
        expect_issue(0, 8'h43);
        max_run = 0;
        pulse_start();
        run_until_drained("rr_order", 40);
        tick();
        chk("b2b_val_run", max_run, 4);

        // Stall: held instruction stable, no grants.
        GBWEI_instr_rdy = 1'b0;
        add_req(3, 10, 5);
        add_req(4, 2, 2);
        expect_issue(3, 8'hAA);
        expect_issue(4, 8'h42);
        tick();
        ng0 = ngrant;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_data", int'(WEIGB_instr_data), 8'hAA);
            chk("stall_which", int'(Which_PEB), 3);
        end
        chk("stall_no_grant", ngrant - ng0, 0);
        GBWEI_instr_rdy = 1'b1;
        run_until_drained("stall", 40);
`ifdef WEI_ISSUE_STATS_EN
        chk("stall_cnt", int'(stall_cnt), 5);
        chk("issue_cnt_a", int'(issue_cnt), 6);
`endif

        // Invalid requests are consumed and flagged.
        chk("drop_err_clear", int'(drop_err), 0);
        add_req(5, 7, 0);
        add_req(6, 27, 1);
        add_req(7, 20, 6);
        expect_issue(7, 8'hD4);
        run_until_drained("drop", 40);
        chk("drop_err_set", int'(drop_err), 1);

        // Flush while stalled with requests pending.
        GBWEI_instr_rdy = 1'b0;
        add_req(8, 1, 1);
        add_req(9, 2, 2);
        add_req(10, 3, 3);
        add_req(11, 4, 4);
        add_req(12, 5, 5);
        tick();
        tick();
        chk("pre_flush_val", int'(WEIGB_instr_val), 1);
        CCUWEI_flush = 1'b1;
        tick();
        CCUWEI_flush = 1'b0;
        GBWEI_instr_rdy = 1'b1;
        ng0 = ngrant;
        chk("flush_val", int'(WEIGB_instr_val), 0);
        repeat (5) tick();
        chk("flush_no_grant", ngrant - ng0, 0);
        chk("flush_pending", pending(), 4);
        chk("flush_val_idle", int'(WEIGB_instr_val), 0);

        // Unlimited budget: 20 instructions, no issue_done.
        Instr_num = 12'd0;
        expect_issue(9, 8'h42);
        expect_issue(10, 8'h63);
        expect_issue(11, 8'h84);
        expect_issue(12, 8'hA5);
        pulse_start();
        chk("start_clears_drop", int'(drop_err), 0);
        run_until_drained("unlim_a", 40);
        for (int k = 0; k < 16; k++) begin
            int p;
            p = (13 + k) % 16;
            add_req(p, p, (p % 7) + 1);
            expect_issue(p, (((p % 7) + 1) << 5) | p);
        end
        run_until_drained("unlim_b", 60);
        repeat (3) tick();
        chk("unlim_no_done", done_cnt, 1);
`ifdef WEI_ISSUE_STATS_EN
        chk("issue_cnt_b", int'(issue_cnt), 20);
        chk("stall_cnt_b", int'(stall_cnt), 0);
`endif
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wei_instr_issue.md
# wei_instr_issue

Weight-instruction initiator. Collects weight-fetch requests from the NUM_PEB PE blocks and arbitrates them round-robin. Each granted request is packed into an 8-bit weight instruction {burst_len[2:0], pe_idx[4:0]} plus a PEB index, and driven to the global-buffer weight-address responder over the WEIGB_instr val/rdy handshake. Sits between the PEB array and the GB weight path, one instance per chip.

## Interface
- NUM_PEB, 16, number of PE blocks (requesters); PEB index width 4
- PE_NUM, 27, PEs per PEB; pe_idx must be < PE_NUM
- INSTR_WIDTH, 8, instruction width: [7:5] burst length, [4:0] PE index
- CNT_WIDTH, 12, width of instruction budget counter
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- CCUWEI_start  in  1  pulse: start new fetch cycle, clears counters and arbiter pointer
- CCUWEI_flush  in  1  pulse: abort, drop held instruction, stop granting
- Instr_num  in  CNT_WIDTH  instructions to issue this cycle; 0 = unlimited
- PEB_req_val  in  NUM_PEB  per-PEB request valid
- PEB_req_pe  in  NUM_PEB*5  per-PEB PE index, PEB i at [5i+:5]
- PEB_req_len  in  NUM_PEB*3  per-PEB burst length 1..7, PEB i at [3i+:3]
- PEB_req_rdy  out  NUM_PEB  one-hot grant, combinational
- WEIGB_instr_val  out  1  instruction valid to GB
- GBWEI_instr_rdy  in  1  GB ready
- Which_PEB  out  4  PEB index of held instruction
- WEIGB_instr_data  out  INSTR_WIDTH  {len, pe_idx}
- issue_done  out  1  one-cycle pulse when the Instr_num-th instruction fires
- drop_err  out  1  sticky: a len==0 or pe_idx>=PE_NUM request was dropped; cleared by start

## Operation
- States: IDLE (no grants), RUN (granting), DONE (budget met, no grants). Reset → IDLE.
- IDLE→RUN on CCUWEI_start.
- RUN→DONE when a fire completes the budget (count == Instr_num-1, Instr_num≠0).
- DONE→RUN on CCUWEI_start.
- Any state→IDLE on CCUWEI_flush. Flush wins over start in the same cycle.
- Output stage is one register (hold_v, Which_PEB, WEIGB_instr_data). WEIGB_instr_val = hold_v.
- fire = hold_v & GBWEI_instr_rdy.
- can_load = (state==RUN) & ~flush & (~hold_v | fire) & ~budget_last_fire, where budget_last_fire = fire & count==Instr_num-1 & Instr_num≠0.
- Arbiter: round-robin over PEB_req_val, starting at ptr; ptr = winner+1 mod NUM_PEB after each grant; ptr reset to 0 by start and reset.
- Grant when can_load. PEB_req_rdy[winner]=1 only then, and the request is consumed.
- Invalid request (len==0 or pe_idx>=PE_NUM): granted (consumed), not loaded, drop_err set; it does not count toward the budget.
- Issue counter increments on each fire; cleared by start and flush.
- issue_done = budget_last_fire, registered to the next cycle.
- Flush: hold_v cleared next cycle even if fire is concurrent (the fire still counts for GB; the counter is cleared anyway).

## Timing
- Reset values: WEIGB_instr_val 0, Which_PEB 0, WEIGB_instr_data 0, PEB_req_rdy 0, issue_done 0, drop_err 0.
- Request granted at cycle t → WEIGB_instr_val=1 at t+1.
- Back-to-back: when fire and grant occur at t, the new instruction is valid at t+1 with no bubble. Peak rate is one instruction per cycle; the GB throttles by holding rdy low for len-1 cycles per burst.
- Held instruction is stable while val=1 and rdy=0 (no retraction).
- start while hold_v=1 in RUN: the held instruction stays and counts toward the new budget.

## Configuration
- WEI_ISSUE_STATS_EN defined: adds outputs stall_cnt[15:0] and issue_cnt[15:0], both saturating and cleared by start.
  - stall_cnt counts cycles with val=1 & rdy=0.
  - issue_cnt counts fires.
- Undefined: these ports and their counters are absent. All other behaviour is identical.

## Structure
- Shared package (wei_pkg): INSTR_WIDTH, field positions LEN_MSB/LEN_LSB/PE_MSB/PE_LSB, PE_NUM, NUM_PEB, state encoding (IDLE/RUN/DONE).
- Sub-module rr_arbiter (parameter N). Inputs: req, ptr, en. Outputs: one-hot grant and winner index. Purely combinational; ptr register kept in the parent.

## Test plan
- Reset, then start with Instr_num=3. PEB 2 requests pe=5 len=4 and holds; rdy=1 → data 0x85 with Which_PEB=2 one cycle after grant; issue_done after the 3rd fire.
- PEBs 0, 1, 15 request simultaneously, rdy=1 → grant order 0, 1, 15, then 0; val high on consecutive cycles.
- rdy held 0 for 5 cycles with val=1 → data stable, no further PEB_req_rdy; with the macro, stall_cnt=5.
- Request with len=0 and one with pe=27 → both consumed, neither issued, drop_err=1; the next valid request is issued normally.
- Flush asserted while val=1, rdy=0, with 4 requests pending → val=0 next cycle, no grants until start.
- Instr_num=0, 20 requests → all 20 issued, issue_done never asserted.
